// File: rtl/inv_bar_renderer_pkg.sv
// Shared constants and types for the inventory-bar renderer.
// Holds the slot keycodes, the render latency and the pixel metadata struct.
package inv_bar_renderer_pkg;

   localparam logic [7:0] KEY_SLOT0 = 8'h1E;
   localparam logic [7:0] KEY_SLOT1 = 8'h1F;
   localparam logic [7:0] KEY_SLOT2 = 8'h20;
   localparam logic [7:0] KEY_SLOT3 = 8'h21;

   localparam int RENDER_LAT = 3;

   typedef struct packed {
      logic       in_win;
      logic [6:0] col;
      logic [3:0] row;
   } pix_meta_t;

endpackage

// File: rtl/inv_bar_renderer_slot_select.sv
// Keyboard slot selection: detects new presses of keys 1-4 and commits the
// chosen slot and bar visibility only at the start of a frame.
module inv_slot_select
   import inv_bar_renderer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] keycode,
   input  logic       vs_in,
   input  logic       show_bar,
   output logic [1:0] sel_slot,
   output logic       show_q
);

   logic [7:0] last_key;
   logic [1:0] pending_slot;
   logic [1:0] next_pending;
   logic       vs_q;
   logic       press;
   logic       vs_fall;

   // A press arriving on the frame-start cycle is forwarded straight into the commit.
   always_comb begin
      press        = (keycode != last_key) && (keycode >= KEY_SLOT0) && (keycode <= KEY_SLOT3);
      next_pending = press ? 2'(keycode - KEY_SLOT0) : pending_slot;
      vs_fall      = vs_q && !vs_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_key     <= 8'd0;
         pending_slot <= 2'd0;
         vs_q         <= 1'b1;
         sel_slot     <= 2'd0;
         show_q       <= 1'b0;
      end else begin
         last_key     <= keycode;
         pending_slot <= next_pending;
         vs_q         <= vs_in;
         if (vs_fall) begin
            sel_slot <= next_pending;
            show_q   <= show_bar;
         end
      end
   end

endmodule

// File: rtl/inv_bar_renderer.sv
// Inventory-bar renderer: scan position -> sprite ROM address -> keyed and
// highlighted pixel, with syncs delayed to stay aligned with the pixel.
module inv_bar_renderer
   import inv_bar_renderer_pkg::*;
#(
   parameter logic [9:0]  BAR_X      = 10'd200,
   parameter logic [9:0]  BAR_Y      = 10'd440,
   parameter int          BAR_W      = 120,
   parameter int          BAR_H      = 10,
   parameter int          SCALE_LOG2 = 1,
   parameter int          NUM_SLOTS  = 4,
   parameter logic [23:0] KEY_RGB    = 24'h4751a3,
   parameter logic [23:0] HILITE_RGB = 24'hffd700
)
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        blank_n_in,
   input  logic [7:0]  keycode,
   input  logic        show_bar,
   output logic [10:0] rom_addr,
   input  logic [23:0] rom_data,
   output logic [23:0] pixel_rgb,
   output logic        pixel_on,
   output logic        hs_out,
   output logic        vs_out,
   output logic        blank_n_out,
   output logic [1:0]  sel_slot
);

   localparam int          SLOT_W = BAR_W / NUM_SLOTS;
   localparam logic [10:0] X_END  = 11'(BAR_X) + 11'(BAR_W << SCALE_LOG2);
   localparam logic [10:0] Y_END  = 11'(BAR_Y) + 11'(BAR_H << SCALE_LOG2);

   logic            show_q;
   logic [10:0]     dx, dy, dx_off, dy_off;
   logic            win;
   pix_meta_t       meta_next, meta1, meta2;
   logic [10:0]     addr_next;
   logic [1:0]      slot;
   logic [6:0]      slot_base, slot_off;
   logic            border;
   logic [23:0]     rgb_next;
   logic            on_next;
   logic [RENDER_LAT-1:0] hs_sr, vs_sr, blank_sr;

   inv_slot_select u_slot_select (
      .clk      (Clk),
      .reset    (Reset),
      .keycode  (keycode),
      .vs_in    (vs_in),
      .show_bar (show_bar),
      .sel_slot (sel_slot),
      .show_q   (show_q)
   );

   // Window test at 11 bits so the right/bottom edges cannot wrap.
   always_comb begin
      dx        = {1'b0, DrawX};
      dy        = {1'b0, DrawY};
      dx_off    = dx - 11'(BAR_X);
      dy_off    = dy - 11'(BAR_Y);
      win       = show_q && (dx >= 11'(BAR_X)) && (dx < X_END)
                         && (dy >= 11'(BAR_Y)) && (dy < Y_END);
      meta_next = '0;
      addr_next = 11'd0;
      if (win) begin
         meta_next.in_win = 1'b1;
         meta_next.col    = 7'(dx_off >> SCALE_LOG2);
         meta_next.row    = 4'(dy_off >> SCALE_LOG2);
         addr_next        = 11'(meta_next.row) * 11'(BAR_W) + 11'(meta_next.col);
      end
   end

   // Slot index by a compare chain against slot boundaries.
   always_comb begin
      slot      = 2'd0;
      slot_base = 7'd0;
      for (int i = 1; i < NUM_SLOTS; i++) begin
         if (meta2.col >= 7'(i * SLOT_W)) begin
            slot      = 2'(i);
            slot_base = 7'(i * SLOT_W);
         end
      end
      slot_off = meta2.col - slot_base;
      border   = meta2.in_win && (slot == sel_slot)
                 && ((slot_off == 7'd0) || (slot_off == 7'(SLOT_W - 1))
                     || (meta2.row == 4'd0) || (meta2.row == 4'(BAR_H - 1)));
      rgb_next = 24'd0;
      on_next  = 1'b0;
      if (border) begin
         rgb_next = HILITE_RGB;
         on_next  = 1'b1;
      end else if (meta2.in_win && (rom_data != KEY_RGB)) begin
         rgb_next = rom_data;
         on_next  = 1'b1;
      end
   end

   // Metadata rides alongside the ROM's own address register to meet rom_data.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr  <= 11'd0;
         meta1     <= '0;
         meta2     <= '0;
         pixel_rgb <= 24'd0;
         pixel_on  <= 1'b0;
         hs_sr     <= '1;
         vs_sr     <= '1;
         blank_sr  <= '0;
      end else begin
         rom_addr  <= addr_next;
         meta1     <= meta_next;
         meta2     <= meta1;
         pixel_rgb <= rgb_next;
         pixel_on  <= on_next;
         hs_sr     <= {hs_sr[RENDER_LAT-2:0], hs_in};
         vs_sr     <= {vs_sr[RENDER_LAT-2:0], vs_in};
         blank_sr  <= {blank_sr[RENDER_LAT-2:0], blank_n_in};
      end
   end

   assign hs_out      = hs_sr[RENDER_LAT-1];
   assign vs_out      = vs_sr[RENDER_LAT-1];
   assign blank_n_out = blank_sr[RENDER_LAT-1];

endmodule

// File: tb/tb_inv_bar_renderer.sv
// Directed bench for inv_bar_renderer with a small behavioural sprite ROM.
module tb_inv_bar_renderer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX, DrawY;
   logic        hs_in, vs_in, blank_n_in;
   logic [7:0]  keycode;
   logic        show_bar;
   logic [10:0] rom_addr;
   logic [23:0] rom_data = 24'd0;
   logic [23:0] pixel_rgb;
   logic        pixel_on;
   logic        hs_out, vs_out, blank_n_out;
   logic [1:0]  sel_slot;

   int testsRun = 0;
   int testsFailed = 0;
   logic [2:0] hist [0:31];
   logic [2:0] v;

   inv_bar_renderer dut (
      .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
      .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
      .keycode(keycode), .show_bar(show_bar),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .pixel_rgb(pixel_rgb), .pixel_on(pixel_on),
      .hs_out(hs_out), .vs_out(vs_out), .blank_n_out(blank_n_out),
      .sel_slot(sel_slot)
   );

   always #5 Clk = ~Clk;

   // Sprite ROM: one-cycle read; address 122 holds the colour key.
   function automatic logic [23:0] romWord(input logic [10:0] a);
      if (a == 11'd122) return 24'h4751a3;
      return {a[7:0], ~a[7:0], 8'h5a};
   endfunction

   always @(posedge Clk) rom_data <= romWord(rom_addr);

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
      DrawX = x;
      DrawY = y;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic commitFrame();
      vs_in = 1'b0;
      tick();
      vs_in = 1'b1;
      tick();
   endtask

   initial begin
      Reset = 1'b1; applyStimulus(10'd0, 10'd0);
      hs_in = 1'b1; vs_in = 1'b1; blank_n_in = 1'b1;
      keycode = 8'h00; show_bar = 1'b1;
      tick(2);
      Reset = 1'b0;
      tick();
      checkOutput("reset_sel_slot", 32'(sel_slot), 32'd0);

      commitFrame();
      applyStimulus(10'd200, 10'd440);
      tick(3);
      checkOutput("pre_reset_on", 32'(pixel_on), 32'd1);
      checkOutput("pre_reset_rgb", 32'(pixel_rgb), 32'hffd700);

      // Mid-frame reset with busy inputs: nothing may leak through.
      Reset = 1'b1; hs_in = 1'b0; vs_in = 1'b0; blank_n_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("reset_syncs", {29'd0, hs_out, vs_out, blank_n_out}, 32'b110);
         checkOutput("reset_pixel_on", 32'(pixel_on), 32'd0);
         checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
      end
      Reset = 1'b0; hs_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("post_reset_off", 32'(pixel_on), 32'd0);
      end
      tick();
      checkOutput("post_reset_hilite", 32'(pixel_rgb), 32'hffd700);
      vs_in = 1'b1;
      tick();

      // Select slot 1 so slot 0 shows plain ROM pixels.
      keycode = 8'h1F; tick();
      keycode = 8'h00; tick();
      commitFrame();
      checkOutput("sel_slot_1", 32'(sel_slot), 32'd1);

      applyStimulus(10'd202, 10'd442);
      tick();
      checkOutput("addr_121", 32'(rom_addr), 32'd121);
      tick(2);
      checkOutput("pix_121_rgb", 32'(pixel_rgb), 32'h79865a);
      checkOutput("pix_121_on", 32'(pixel_on), 32'd1);

      applyStimulus(10'd204, 10'd442);
      tick(3);
      checkOutput("key_on", 32'(pixel_on), 32'd0);
      checkOutput("key_rgb", 32'(pixel_rgb), 32'd0);

      applyStimulus(10'd439, 10'd440);
      tick();
      checkOutput("addr_col119", 32'(rom_addr), 32'd119);
      tick(2);
      checkOutput("pix_119_rgb", 32'(pixel_rgb), 32'h77885a);

      applyStimulus(10'd440, 10'd440);
      tick();
      checkOutput("addr_right_edge", 32'(rom_addr), 32'd0);
      tick(2);
      checkOutput("on_right_edge", 32'(pixel_on), 32'd0);

      applyStimulus(10'd300, 10'd459);
      tick();
      checkOutput("addr_1130", 32'(rom_addr), 32'd1130);
      applyStimulus(10'd300, 10'd460);
      tick();
      checkOutput("addr_bottom_edge", 32'(rom_addr), 32'd0);
      tick(2);
      checkOutput("on_bottom_edge", 32'(pixel_on), 32'd0);

      applyStimulus(10'd202, 10'd442);
      tick(3);
      applyStimulus(10'd199, 10'd445);
      tick(3);
      checkOutput("on_left_edge", 32'(pixel_on), 32'd0);

      // Held key: selection moves only at the next frame start.
      keycode = 8'h20;
      tick(10);
      checkOutput("held_no_commit", 32'(sel_slot), 32'd1);
      vs_in = 1'b0; tick();
      checkOutput("sel_slot_2", 32'(sel_slot), 32'd2);
      vs_in = 1'b1; tick();
      keycode = 8'h00;

      applyStimulus(10'd320, 10'd444);
      tick(3);
      checkOutput("hilite_col60", 32'(pixel_rgb), 32'hffd700);
      applyStimulus(10'd330, 10'd444);
      tick(3);
      checkOutput("slot2_interior", 32'(pixel_rgb), 32'h31ce5a);
      applyStimulus(10'd378, 10'd444);
      tick(3);
      checkOutput("hilite_col89", 32'(pixel_rgb), 32'hffd700);
      applyStimulus(10'd380, 10'd444);
      tick(3);
      checkOutput("slot3_col90", 32'(pixel_rgb), 32'h4ab55a);
      applyStimulus(10'd330, 10'd458);
      tick(3);
      checkOutput("hilite_row9", 32'(pixel_rgb), 32'hffd700);

      // Press on the very cycle the frame starts.
      keycode = 8'h1F; vs_in = 1'b0;
      tick();
      checkOutput("press_at_vs", 32'(sel_slot), 32'd1);
      vs_in = 1'b1; keycode = 8'h00; tick();
      keycode = 8'h05; tick();
      keycode = 8'h00; tick();
      commitFrame();
      checkOutput("non_slot_key", 32'(sel_slot), 32'd1);

      for (int i = 0; i < 24; i++) begin
         v = 3'($urandom_range(0, 7));
         hs_in = v[2]; vs_in = v[1]; blank_n_in = v[0];
         hist[i] = v;
         tick();
         if (i >= 2) checkOutput("sync_delay", {29'd0, hs_out, vs_out, blank_n_out}, 32'(hist[i-2]));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
